// File: rtl/serial_nibble_assembler_if.sv
// Bundles the serial input, downstream handshake and status flags of the
// serial nibble assembler. The master side drives serial bits and the
// downstream ready; the slave side (the assembler) returns nibble and status.
interface serial_nibble_assembler_if;
    logic       serial_in;
    logic       serial_valid;
    logic       out_ready;
    logic       clear_err;
    logic [3:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       overrun;
    logic       parity_err;

    modport master (
        output serial_in, serial_valid, out_ready, clear_err,
        input  out_data, out_valid, busy, overrun, parity_err
    );

    modport slave (
        input  serial_in, serial_valid, out_ready, clear_err,
        output out_data, out_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/serial_nibble_assembler.sv
// Serial-to-nibble assembler: collects four qualified serial bits into a
// nibble, presents it with a valid/ready handshake and flags dropped bits.
// Optional feature macro: PARITY_CHECK_EN -- a fifth bit carries even parity
// over the data bits; a failing nibble is discarded and ParityErr is set.
module serial_nibble_assembler #(
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    serial_nibble_assembler_if.slave    bus
);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd3
    } state_t;
`endif

    // Writes one serial bit into the nibble at its arrival position,
    // mirroring the position when the first bit is the MSB.
    function automatic logic [3:0] place_bit(input logic [3:0] nib,
                                             input logic [1:0] pos,
                                             input logic       b);
        logic [3:0] res;
        logic [1:0] idx;
        res = nib;
        if (LSB_FIRST != 0) begin
            idx = pos;
        end else begin
            idx = 2'd3 - pos;
        end
        res[idx] = b;
        return res;
    endfunction

`ifdef PARITY_CHECK_EN
    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic calc_even_parity(input logic [3:0] nib);
        return ^nib;
    endfunction
`endif

    state_t     state_q, state_d;
    logic [1:0] count_q, count_d;
    logic [3:0] shift_q, shift_d;
    logic [3:0] data_q, data_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       overrun_q, overrun_d;
    logic       overrun_set;
`ifdef PARITY_CHECK_EN
    logic       parity_err_q, parity_err_d;
    logic       parity_set;
`endif

    // Next-state, nibble assembly and sticky-flag logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_d     = shift_q;
        data_d      = data_q;
        overrun_set = 1'b0;
`ifdef PARITY_CHECK_EN
        parity_set  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.serial_valid) begin
                    shift_d = place_bit(4'h0, 2'd0, bus.serial_in);
                    count_d = 2'd1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bus.serial_valid) begin
                    shift_d = place_bit(shift_q, count_q, bus.serial_in);
                    if (count_q == 2'd3) begin
                        count_d = 2'd0;
`ifdef PARITY_CHECK_EN
                        state_d = ST_PARITY;
`else
                        // The output register only loads when entering HOLD.
                        data_d  = place_bit(shift_q, count_q, bus.serial_in);
                        state_d = ST_HOLD;
`endif
                    end else begin
                        count_d = count_q + 2'd1;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
`ifdef PARITY_CHECK_EN
            ST_PARITY: begin
                if (bus.serial_valid) begin
                    if (bus.serial_in == calc_even_parity(shift_q)) begin
                        data_d  = shift_q;
                        state_d = ST_HOLD;
                    end else begin
                        parity_set = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_HOLD: begin
                if (bus.out_ready) begin
                    if (bus.serial_valid) begin
                        // Handshake and first bit of the next nibble share a cycle.
                        shift_d = place_bit(4'h0, 2'd0, bus.serial_in);
                        count_d = 2'd1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (bus.serial_valid) begin
                        overrun_set = 1'b1;
                    end else begin
                        overrun_set = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 2'd0;
            end
        endcase

        // Set wins over a clear in the same cycle.
        overrun_d    = overrun_set | (overrun_q & ~bus.clear_err);
`ifdef PARITY_CHECK_EN
        parity_err_d = parity_set | (parity_err_q & ~bus.clear_err);
        busy_d       = (state_d == ST_SHIFT) | (state_d == ST_PARITY);
`else
        busy_d       = (state_d == ST_SHIFT);
`endif
        out_valid_d  = (state_d == ST_HOLD);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            count_q      <= 2'd0;
            shift_q      <= 4'h0;
            data_q       <= 4'h0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
`ifdef PARITY_CHECK_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.out_data   = data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_nibble_assembler.sv
// Bench for serial_nibble_assembler: an LSB-first and an MSB-first instance
// share the same stimulus; a table of directed vectors, hand-written corner
// sequences and a random run are checked against a bit-queue reference model.
module tb_serial_nibble_assembler;

`ifdef PARITY_CHECK_EN
    localparam int NBITS = 5;
`else
    localparam int NBITS = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_nibble_assembler_if if_l ();
    serial_nibble_assembler_if if_m ();

    serial_nibble_assembler #(.LSB_FIRST(1)) u_lsb (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_l.slave)
    );

    serial_nibble_assembler #(.LSB_FIRST(0)) u_msb (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_m.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: bits of the nibble being collected, held nibble.
    bit       m_bits[$];
    bit       m_hold;
    bit [3:0] m_out_l;
    bit [3:0] m_out_m;
    bit       m_ovr;
    bit       m_perr;

    typedef struct {
        bit       sv;
        bit       si;
        bit       rdy;
        bit       clr;
        bit [3:0] data;
        bit       valid;
        bit       busy;
        bit       ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_bits.delete();
        m_hold  = 1'b0;
        m_out_l = 4'h0;
        m_out_m = 4'h0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endfunction

    function automatic void model_step(input bit sv, input bit si, input bit rdy, input bit clr);
        bit       ovr_s;
        bit       perr_s;
        bit [3:0] nl;
        bit [3:0] nm;
        bit       par;
        ovr_s  = 1'b0;
        perr_s = 1'b0;
        if (m_hold) begin
            if (rdy) begin
                m_hold = 1'b0;
                if (sv) m_bits.push_back(si);
            end else if (sv) begin
                ovr_s = 1'b1;
            end
        end else if (sv) begin
            m_bits.push_back(si);
            if (m_bits.size() == NBITS) begin
                nl  = 4'h0;
                nm  = 4'h0;
                par = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    nl[i]     = m_bits[i];
                    nm[3 - i] = m_bits[i];
                    par       = par ^ m_bits[i];
                end
                if (NBITS == 4 || m_bits[4] == par) begin
                    m_hold  = 1'b1;
                    m_out_l = nl;
                    m_out_m = nm;
                end else begin
                    perr_s = 1'b1;
                end
                m_bits.delete();
            end
        end
        m_ovr  = ovr_s | (m_ovr & ~clr);
        m_perr = perr_s | (m_perr & ~clr);
    endfunction

    task automatic cmp_model(input string tag);
        chk({tag, "_lsb"},
            {24'h0, if_l.out_data, if_l.out_valid, if_l.busy, if_l.overrun, if_l.parity_err},
            {24'h0, m_out_l, m_hold, (m_bits.size() != 0), m_ovr, m_perr});
        chk({tag, "_msb"},
            {24'h0, if_m.out_data, if_m.out_valid, if_m.busy, if_m.overrun, if_m.parity_err},
            {24'h0, m_out_m, m_hold, (m_bits.size() != 0), m_ovr, m_perr});
    endtask

    task automatic drive(input bit sv, input bit si, input bit rdy, input bit clr);
        if_l.serial_valid = sv;  if_m.serial_valid = sv;
        if_l.serial_in    = si;  if_m.serial_in    = si;
        if_l.out_ready    = rdy; if_m.out_ready    = rdy;
        if_l.clear_err    = clr; if_m.clear_err    = clr;
    endtask

    // One clock: apply inputs, update model at the edge, compare after it.
    task automatic cycle(input bit sv, input bit si, input bit rdy, input bit clr, input string tag);
        drive(sv, si, rdy, clr);
        @(posedge clk);
        model_step(sv, si, rdy, clr);
        #1;
        cmp_model(tag);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        model_reset();
        chk({tag, "_lsb"}, {24'h0, if_l.out_data, if_l.out_valid, if_l.busy, if_l.overrun, if_l.parity_err}, 32'h0);
        chk({tag, "_msb"}, {24'h0, if_m.out_data, if_m.out_valid, if_m.busy, if_m.overrun, if_m.parity_err}, 32'h0);
        rst = 1'b0;
    endtask

    // Four data bits in arrival order, followed by a correct parity bit when enabled.
    task automatic send4(input bit b0, input bit b1, input bit b2, input bit b3, input bit rdy, input string tag);
        cycle(1'b1, b0, rdy, 1'b0, tag);
        cycle(1'b1, b1, rdy, 1'b0, tag);
        cycle(1'b1, b2, rdy, 1'b0, tag);
        cycle(1'b1, b3, rdy, 1'b0, tag);
        if (NBITS == 5) cycle(1'b1, b0 ^ b1 ^ b2 ^ b3, rdy, 1'b0, tag);
    endtask

    function automatic void add(input bit sv, input bit si, input bit rdy, input bit clr,
                                input bit [3:0] data, input bit valid, input bit busy, input bit ovr);
        vec_t v;
        v.sv = sv; v.si = si; v.rdy = rdy; v.clr = clr;
        v.data = data; v.valid = valid; v.busy = busy; v.ovr = ovr;
        tbl.push_back(v);
    endfunction

    initial begin
        // Directed table (data-only framing): 4'hD with ready, 4'h6 stalled,
        // then back-to-back 4'hA / 4'h5.
        add(1, 1, 1, 0, 4'h0, 0, 1, 0);
        add(1, 0, 1, 0, 4'h0, 0, 1, 0);
        add(1, 1, 1, 0, 4'h0, 0, 1, 0);
        add(1, 1, 1, 0, 4'hD, 1, 0, 0);
        add(0, 0, 1, 0, 4'hD, 0, 0, 0);
        add(1, 0, 0, 0, 4'hD, 0, 1, 0);
        add(1, 1, 0, 0, 4'hD, 0, 1, 0);
        add(1, 1, 0, 0, 4'hD, 0, 1, 0);
        add(1, 0, 0, 0, 4'h6, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 4'h6, 1, 0, 1);
        add(0, 0, 0, 1, 4'h6, 1, 0, 0);
        add(0, 0, 1, 0, 4'h6, 0, 0, 0);
        add(1, 0, 1, 0, 4'h6, 0, 1, 0);
        add(1, 1, 1, 0, 4'h6, 0, 1, 0);
        add(1, 0, 1, 0, 4'h6, 0, 1, 0);
        add(1, 1, 1, 0, 4'hA, 1, 0, 0);
        add(1, 1, 1, 0, 4'hA, 0, 1, 0);
        add(1, 0, 1, 0, 4'hA, 0, 1, 0);
        add(1, 1, 1, 0, 4'hA, 0, 1, 0);
        add(1, 0, 1, 0, 4'h5, 1, 0, 0);
        add(0, 0, 1, 0, 4'h5, 0, 0, 0);

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        do_reset("reset_init");

        if (NBITS == 4) begin
            foreach (tbl[i]) begin
                cycle(tbl[i].sv, tbl[i].si, tbl[i].rdy, tbl[i].clr, "tbl_model");
                chk($sformatf("tbl_%0d", i),
                    {24'h0, if_l.out_data, if_l.out_valid, if_l.busy, if_l.overrun, 1'b0},
                    {24'h0, tbl[i].data, tbl[i].valid, tbl[i].busy, tbl[i].ovr, 1'b0});
            end
        end

        // Reset after two bits of a nibble; the next nibble starts clean.
        do_reset("reset_pre034");
        cycle(1'b1, 1'b0, 1'b1, 1'b0, "abort");
        cycle(1'b1, 1'b1, 1'b1, 1'b0, "abort");
        do_reset("reset_mid");
        send4(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "n3");
        chk("abort_lsb_data", {28'h0, if_l.out_data}, 32'h3);
        chk("abort_msb_data", {28'h0, if_m.out_data}, 32'hC);
        chk("abort_valid", {31'h0, if_l.out_valid}, 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, "drain");

        // Mirrored placement: first bit lands in the MSB.
        send4(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "n8");
        chk("msb_first_data", {28'h0, if_m.out_data}, 32'h8);
        chk("lsb_first_data", {28'h0, if_l.out_data}, 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, "drain");
        chk("drain_valid", {31'h0, if_m.out_valid}, 32'h0);

`ifdef PARITY_CHECK_EN
        // 4'h7 with correct parity is delivered; with wrong parity it is dropped.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "p7");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "p7");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "p7");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, "p7");
        chk("par_busy", {31'h0, if_l.busy}, 32'h1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "p7");
        chk("par_ok_valid", {31'h0, if_l.out_valid}, 32'h1);
        chk("par_ok_data", {28'h0, if_l.out_data}, 32'h7);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, "drain");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "p7bad");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "p7bad");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, "p7bad");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, "p7bad");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, "p7bad");
        chk("par_bad_valid", {31'h0, if_l.out_valid}, 32'h0);
        chk("par_bad_err", {31'h0, if_l.parity_err}, 32'h1);
        chk("par_bad_data", {28'h0, if_l.out_data}, 32'h7);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "perr_clr");
        chk("par_err_clr", {31'h0, if_l.parity_err}, 32'h0);
`else
        chk("par_err_tied", {31'h0, if_l.parity_err}, 32'h0);
`endif

        // Random traffic against the reference model, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rnd_rst");
            end else begin
                cycle($urandom_range(0, 9) < 7,
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 9) < 5,
                      $urandom_range(0, 15) == 0,
                      "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_nibble_assembler.md
SERIAL_NIBBLE_ASSEMBLER -- requirements
Module: serial_nibble_assembler

Interface
REQ-001 Parameter LSB_FIRST, default 1; 1 = first accepted bit lands in OutData[0], 0 = first accepted bit lands in OutData[3].
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 SerialIn  input  1  serial data bit, sampled only when SerialValid=1.
REQ-005 SerialValid  input  1  qualifies SerialIn for the current cycle.
REQ-006 OutReady  input  1  downstream 4-bit register stage accepts OutData this cycle.
REQ-007 ClearErr  input  1  synchronous clear of sticky error flags.
REQ-008 OutData  output  4  assembled nibble; feeds the downstream register's data input.
REQ-009 OutValid  output  1  OutData holds a complete nibble.
REQ-010 Busy  output  1  high while at least one bit of an incomplete nibble is held.
REQ-011 Overrun  output  1  sticky; a valid bit was dropped.
REQ-012 ParityErr  output  1  sticky; a parity-failed nibble was discarded (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, PARITY (only with macro) and HOLD.
REQ-014 IDLE, SerialValid=1: the bit is stored as bit 0 of the nibble, the 2-bit count is set to 1, and the FSM moves to SHIFT.
REQ-015 SHIFT, SerialValid=1, count<3: the bit is stored at position count and count increments; SerialValid=0 holds all state (no timeout).
REQ-016 SHIFT, SerialValid=1, count=3: the fourth bit is stored; next state is HOLD (macro off) or PARITY (macro on).
REQ-017 OutValid SHALL be 1 exactly in HOLD: one cycle after the fourth bit is sampled (macro off), or after the parity bit is sampled (macro on).
REQ-018 In HOLD, OutData and OutValid SHALL stay stable until a cycle with OutReady=1 (handshake = OutValid & OutReady).
REQ-019 HOLD, OutReady=1, SerialValid=0: next state is IDLE and OutValid is 0 next cycle.
REQ-020 HOLD, OutReady=1, SerialValid=1: the handshake completes and the bit is taken as bit 0 of the next nibble (next state SHIFT, count=1); no bubble and no drop.
REQ-021 HOLD, OutReady=0, SerialValid=1: the bit is dropped, Overrun is set, and OutData is unchanged.
REQ-022 OutData SHALL update only when entering HOLD; it keeps its last value outside HOLD.
REQ-023 Busy = (state==SHIFT) | (state==PARITY).
REQ-024 Overrun and ParityErr SHALL clear on ClearErr=1 unless a set event occurs in the same cycle; set wins.
REQ-025 LSB_FIRST=0 SHALL mirror the bit placement only; timing is identical.

Reset
REQ-026 While Reset=1, independent of Clock: state=IDLE, count=0, OutData=4'h0, OutValid=0, Busy=0, Overrun=0, ParityErr=0.
REQ-027 Reset asserted mid-nibble or in HOLD SHALL discard the partial or held nibble; the first valid bit after release starts a new nibble at bit 0.

Configuration
REQ-028 Macro PARITY_CHECK_EN defined: after the fourth data bit the FSM enters PARITY and the next valid bit is an even-parity bit over the 4 data bits.
REQ-029 With PARITY_CHECK_EN, correct parity moves the FSM to HOLD; wrong parity discards the nibble, sets ParityErr, returns to IDLE, and leaves OutData unchanged.
REQ-030 Macro PARITY_CHECK_EN undefined: there is no PARITY state, every fourth valid bit completes a nibble, and ParityErr is tied to 0.

Verification
REQ-031 Reset, then SerialValid=1 with bits 1,0,1,1 on consecutive cycles (LSB_FIRST=1), OutReady=1 -> OutData=4'hD and OutValid=1 for one cycle, one cycle after the 4th bit.
REQ-032 Nibble 4'h6 assembled with OutReady=0 for 5 cycles -> OutValid and OutData=4'h6 stay stable; bits sent in that window are dropped and Overrun=1; ClearErr -> Overrun=0.
REQ-033 Back-to-back streams 4'hA then 4'h5 with SerialValid=1 every cycle and OutReady=1 -> handoff in the same cycle as the next bit, both nibbles delivered, Overrun stays 0.
REQ-034 Reset pulse after 2 of 4 bits, then bits for 4'h3 -> OutData=4'h3, with no residue from the aborted nibble.
REQ-035 PARITY_CHECK_EN: nibble 4'h7 with parity bit 1 -> delivered; 4'h7 with parity bit 0 -> OutValid stays 0, ParityErr=1, OutData unchanged.
REQ-036 LSB_FIRST=0, bits 1,0,0,0 -> OutData=4'h8.
